gon_multicast_sender: RTL and testbench
=======================================

# gon_multicast_sender

Source end of the GON Y-bus multicast protocol. Buffers packets of (row tag, column tag, value) from the global buffer side and drives one Y bus: tag, column tag, value and enable. Holds each packet stable until the bus returns ready, the OR of all Y-controller ready outputs. Sits between the global-buffer read port and the Y-bus controllers of one PE array.

## Interface
Parameters:
- ROW_LEN, 4: row tag width; matches Y-controller id width.
- ID_LEN, 5: column tag width forwarded to X buses.
- VALUE_LEN, 32: payload width.
- FIFO_DEPTH, 4: input FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  FIFO not full; a packet is accepted when in_valid & in_ready.
- in_row_tag  in  ROW_LEN  destination row id.
- in_col_tag  in  ID_LEN  destination column tag.
- in_value  in  VALUE_LEN  payload.
- bus_tag  out  ROW_LEN  row tag driven to every Y controller.
- bus_col_tag  out  ID_LEN  column tag on the Y bus.
- bus_value  out  VALUE_LEN  payload on the Y bus.
- bus_enable  out  1  packet present on the bus.
- bus_ready  in  1  OR of the Y-controller ready outputs.
- busy  out  1  FIFO non-empty or bus_enable high.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- clear_stats  in  1  clears the statistics counters.
- sent_count  out  32  completed bus transfers.
- stall_count  out  32  cycles with bus_enable & !bus_ready.

## Operation
- A bus transfer completes in any cycle where bus_enable & bus_ready are both high.
- The FSM has two states:
  - IDLE: bus_enable = 0. All bus outputs are 0.
  - SEND: bus_enable = 1. bus_tag, bus_col_tag and bus_value hold the current packet and do not change until the transfer completes.
- IDLE → SEND when the FIFO is non-empty. The FIFO head is popped into the output register.
- In SEND, while bus_ready is low, the state and outputs hold.
- In SEND, when bus_ready is high:
  - FIFO non-empty: pop the next head, stay in SEND. This gives back-to-back transfers.
  - FIFO empty: go to IDLE.
- Idle bus outputs are forced to zero. bus_tag 0 matches the Y-controller reset id, so the controllers are safe only because bus_enable is low.
- FIFO full: in_ready = 0. A push is refused even if a pop happens in the same cycle. in_ready depends only on the registered count.
- FIFO empty with a push in the same cycle: the packet is written first and popped no earlier than the next cycle. There is no bypass.
- A tag that no controller holds leaves bus_ready low forever. The block waits; it has no timeout. stall_count exposes the hang.
- Reset mid-operation clears the FIFO and returns to IDLE. The in-flight packet is dropped. No partial transfer is reported.

## Timing
- Reset values: in_ready 1, bus_enable 0, bus_tag/bus_col_tag/bus_value 0, busy 0, fifo_count 0, sent_count 0, stall_count 0.
- Latency: packet accepted at edge N; bus_enable is high after edge N+2, when the FIFO was empty and the state was IDLE.
- Throughput: one packet per cycle while bus_ready is held high and the FIFO is non-empty.
- After the last transfer, bus_enable falls on the next edge.
- All outputs are registered. No output depends combinationally on bus_ready or in_valid.

## Configuration
- GON_SENDER_STATS_EN defined:
  - sent_count increments on each completed transfer.
  - stall_count increments on each cycle with bus_enable & !bus_ready.
  - Both counters saturate at 32'hFFFF_FFFF.
  - clear_stats zeroes both counters synchronously and has priority over an increment in the same cycle.
- Not defined: the ports still exist, sent_count and stall_count are tied to 0, clear_stats is ignored, and no counter flops are built.

## Structure
- Shared package gon_pkg:
  - default ROW_LEN, ID_LEN and VALUE_LEN constants;
  - sender state enum (IDLE, SEND);
  - packed packet struct {row_tag, col_tag, value}.
- One sub-module: gon_sync_fifo, a parameterized synchronous FIFO with push/pop, full/empty and count, and synchronous active-high reset.

## Test plan
- Reset, then one packet (row 3, col 5, value 0xDEADBEEF) with bus_ready held high → bus_enable high for exactly 1 cycle, at edge N+2, carrying those values; then IDLE with zeroed outputs.
- 4 packets pushed back-to-back, bus_ready held low 10 cycles then high → outputs stable for all 10 stall cycles; 4 transfers on consecutive cycles; stall_count = 10, sent_count = 4.
- FIFO_DEPTH = 4, bus_ready low, in_valid held high → in_ready falls after 4 accepts; the 5th packet is not accepted until the first transfer completes.
- rst asserted mid-SEND with 3 packets queued → next cycle bus_enable = 0, fifo_count = 0, in_ready = 1; later packets flow normally.
- With GON_SENDER_STATS_EN defined, clear_stats asserted in the same cycle as a transfer → sent_count = 0 next cycle, not 1.
- Without GON_SENDER_STATS_EN, run the second scenario → sent_count and stall_count stay 0 throughout.

Source files
------------

// File: rtl/gon_pkg.sv
// Shared GON Y-bus definitions: default field widths, sender FSM states and packet layout.
package gon_pkg;

  localparam int unsigned ROW_LEN_DEF   = 4;
  localparam int unsigned ID_LEN_DEF    = 5;
  localparam int unsigned VALUE_LEN_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sender_state_e;

  typedef struct packed {
    logic [ROW_LEN_DEF-1:0]   row_tag;
    logic [ID_LEN_DEF-1:0]    col_tag;
    logic [VALUE_LEN_DEF-1:0] value;
  } gon_packet_t;

endpackage

// File: rtl/gon_sync_fifo.sv
// Parameterized synchronous FIFO; push is refused when full, pop is ignored when empty.
module gon_sync_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/gon_multicast_sender.sv
// GON Y-bus multicast source: FIFO-buffered packets held on the bus until bus_ready.
// Statistics counters are built only when GON_SENDER_STATS_EN is defined.
module gon_multicast_sender
  import gon_pkg::*;
#(
  parameter int unsigned ROW_LEN    = ROW_LEN_DEF,
  parameter int unsigned ID_LEN     = ID_LEN_DEF,
  parameter int unsigned VALUE_LEN  = VALUE_LEN_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROW_LEN-1:0]            in_row_tag,
  input  logic [ID_LEN-1:0]             in_col_tag,
  input  logic [VALUE_LEN-1:0]          in_value,
  output logic [ROW_LEN-1:0]            bus_tag,
  output logic [ID_LEN-1:0]             bus_col_tag,
  output logic [VALUE_LEN-1:0]          bus_value,
  output logic                          bus_enable,
  input  logic                          bus_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          clear_stats,
  output logic [31:0]                   sent_count,
  output logic [31:0]                   stall_count
);

  localparam int unsigned PKT_W = ROW_LEN + ID_LEN + VALUE_LEN;

  sender_state_e      state;
  sender_state_e      state_next;
  logic               pending_q;
  logic               pop_c;
  logic               push_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PKT_W-1:0]   head;

  assign in_ready   = ~fifo_full;
  assign push_c     = in_valid & ~fifo_full;
  assign bus_enable = (state == SEND);
  assign busy       = bus_enable | ~fifo_empty;

  gon_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata ({in_row_tag, in_col_tag, in_value}),
    .pop   (pop_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // IDLE wakes on the registered non-empty flag, so a fresh entry waits one cycle before its pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state     <= state_next;
      pending_q <= ~fifo_empty;
    end
  end

  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending_q && !fifo_empty) begin
          pop_c      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus_ready) begin
          if (!fifo_empty) pop_c = 1'b1;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus payload holds until the transfer completes and reads as zero while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_tag     <= '0;
      bus_col_tag <= '0;
      bus_value   <= '0;
    end else if (pop_c) begin
      {bus_tag, bus_col_tag, bus_value} <= head;
    end else if (bus_enable && bus_ready) begin
      bus_tag     <= '0;
      bus_col_tag <= '0;
      bus_value   <= '0;
    end
  end

`ifdef GON_SENDER_STATS_EN
  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      sent_count  <= '0;
      stall_count <= '0;
    end else begin
      if (bus_enable && bus_ready && (sent_count != 32'hFFFF_FFFF))
        sent_count <= sent_count + 32'd1;
      if (bus_enable && !bus_ready && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats;
  assign sent_count         = '0;
  assign stall_count        = '0;
`endif

endmodule

// File: tb/tb_gon_multicast_sender.sv
// Directed self-checking bench for gon_multicast_sender (default and GON_SENDER_STATS_EN builds).
module tb_gon_multicast_sender;
  import gon_pkg::*;

`ifdef GON_SENDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_row_tag;
  logic [4:0]  in_col_tag;
  logic [31:0] in_value;
  logic [3:0]  bus_tag;
  logic [4:0]  bus_col_tag;
  logic [31:0] bus_value;
  logic        bus_enable;
  logic        bus_ready;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        clear_stats;
  logic [31:0] sent_count;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  gon_multicast_sender #(
    .ROW_LEN    (4),
    .ID_LEN     (5),
    .VALUE_LEN  (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row_tag  (in_row_tag),
    .in_col_tag  (in_col_tag),
    .in_value    (in_value),
    .bus_tag     (bus_tag),
    .bus_col_tag (bus_col_tag),
    .bus_value   (bus_value),
    .bus_enable  (bus_enable),
    .bus_ready   (bus_ready),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .clear_stats (clear_stats),
    .sent_count  (sent_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input gon_packet_t p);
    in_valid   = 1'b1;
    in_row_tag = p.row_tag;
    in_col_tag = p.col_tag;
    in_value   = p.value;
  endtask

  task automatic check_bus(input string tag, input gon_packet_t p, input logic en);
    check({tag, "_en"},    64'(bus_enable),  64'(en));
    check({tag, "_tag"},   64'(bus_tag),     64'(p.row_tag));
    check({tag, "_col"},   64'(bus_col_tag), 64'(p.col_tag));
    check({tag, "_value"}, 64'(bus_value),   64'(p.value));
  endtask

  gon_packet_t zero_pkt;
  gon_packet_t pk [6];

  initial begin
    zero_pkt    = '0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_row_tag  = '0;
    in_col_tag  = '0;
    in_value    = '0;
    bus_ready   = 1'b0;
    clear_stats = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check_bus("rst", zero_pkt, 1'b0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_sent", 64'(sent_count), 64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);

    // Single packet, bus_ready high: enable for one cycle at N+2
    bus_ready = 1'b1;
    drive('{row_tag: 4'd3, col_tag: 5'd5, value: 32'hDEAD_BEEF});
    step();
    in_valid = 1'b0;
    check("one_n0_en", 64'(bus_enable), 64'd0);
    check("one_n0_count", 64'(fifo_count), 64'd1);
    check("one_n0_busy", 64'(busy), 64'd1);
    step();
    check("one_n1_en", 64'(bus_enable), 64'd0);
    step();
    check_bus("one_n2", '{row_tag: 4'd3, col_tag: 5'd5, value: 32'hDEAD_BEEF}, 1'b1);
    check("one_n2_count", 64'(fifo_count), 64'd0);
    step();
    check_bus("one_n3", zero_pkt, 1'b0);
    check("one_n3_busy", 64'(busy), 64'd0);
    check("one_sent", 64'(sent_count), STATS ? 64'd1 : 64'd0);
    check("one_stall", 64'(stall_count), 64'd0);

    // Four packets back-to-back, 10 stall cycles, then four consecutive transfers
    for (int i = 0; i < 4; i++)
      pk[i] = '{row_tag: 4'(i + 1), col_tag: 5'(i + 10), value: 32'h100 + 32'(i)};
    bus_ready   = 1'b0;
    clear_stats = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(pk[i]);
      step();
      clear_stats = 1'b0;
    end
    in_valid = 1'b0;
    check_bus("stall_start", pk[0], 1'b1);
    check("stall_start_count", 64'(fifo_count), 64'd3);
    check("stall_start_stall", 64'(stall_count), STATS ? 64'd1 : 64'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      check_bus("stall_hold", pk[0], 1'b1);
    end
    check("stall_total", 64'(stall_count), STATS ? 64'd10 : 64'd0);
    check("stall_sent", 64'(sent_count), 64'd0);
    bus_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check_bus("b2b", pk[i], 1'b1);
    end
    step();
    check_bus("b2b_done", zero_pkt, 1'b0);
    check("b2b_sent", 64'(sent_count), STATS ? 64'd4 : 64'd0);
    check("b2b_stall", 64'(stall_count), STATS ? 64'd10 : 64'd0);
    check("b2b_busy", 64'(busy), 64'd0);

    // FIFO full: one packet on the stalled bus, then four more fill the FIFO
    for (int i = 0; i < 6; i++)
      pk[i] = '{row_tag: 4'(i), col_tag: 5'(i + 8), value: 32'hA0 + 32'(i)};
    bus_ready = 1'b0;
    drive(pk[0]);
    step();
    in_valid = 1'b0;
    step();
    step();
    check_bus("full_head", pk[0], 1'b1);
    check("full_head_count", 64'(fifo_count), 64'd0);
    for (int i = 1; i < 5; i++) begin
      check("full_ready_before", 64'(in_ready), 64'd1);
      drive(pk[i]);
      step();
    end
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(pk[5]);
    step();
    step();
    check("full_hold_count", 64'(fifo_count), 64'd4);
    check("full_hold_ready", 64'(in_ready), 64'd0);
    bus_ready = 1'b1;
    step();
    check_bus("full_x0", pk[1], 1'b1);
    check("full_x0_count", 64'(fifo_count), 64'd3);
    check("full_x0_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_bus("full_x1", pk[2], 1'b1);
    check("full_x1_count", 64'(fifo_count), 64'd3);
    for (int i = 3; i < 6; i++) begin
      step();
      check_bus("full_drain", pk[i], 1'b1);
    end
    step();
    check_bus("full_end", zero_pkt, 1'b0);
    check("full_end_count", 64'(fifo_count), 64'd0);

    // Reset in SEND with three packets queued
    for (int i = 0; i < 4; i++)
      pk[i] = '{row_tag: 4'(i + 4), col_tag: 5'(i + 20), value: 32'h200 + 32'(i)};
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(pk[i]);
      step();
    end
    in_valid = 1'b0;
    check("mrst_pre_count", 64'(fifo_count), 64'd3);
    check("mrst_pre_en", 64'(bus_enable), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_bus("mrst", zero_pkt, 1'b0);
    check("mrst_count", 64'(fifo_count), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_sent", 64'(sent_count), 64'd0);
    check("mrst_stall", 64'(stall_count), 64'd0);
    bus_ready = 1'b1;
    drive('{row_tag: 4'd9, col_tag: 5'd17, value: 32'h0BAD_F00D});
    step();
    in_valid = 1'b0;
    step();
    check("mrst_n1_en", 64'(bus_enable), 64'd0);
    step();
    check_bus("mrst_after", '{row_tag: 4'd9, col_tag: 5'd17, value: 32'h0BAD_F00D}, 1'b1);
    step();
    check_bus("mrst_after_idle", zero_pkt, 1'b0);
    check("mrst_after_sent", 64'(sent_count), STATS ? 64'd1 : 64'd0);

    // clear_stats in the same cycle as a transfer
    drive('{row_tag: 4'd2, col_tag: 5'd3, value: 32'h0000_0042});
    step();
    in_valid = 1'b0;
    step();
    step();
    check("clr_en", 64'(bus_enable), 64'd1);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clr_sent", 64'(sent_count), 64'd0);
    check("clr_en_after", 64'(bus_enable), 64'd0);
    step();
    check("clr_sent_hold", 64'(sent_count), 64'd0);
    check("clr_stall", 64'(stall_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
